// File: rtl/gray_sync_decoder_pkg.sv
// gray_sync_decoder_pkg: shared async-FIFO pointer defaults and Gray/binary helpers
package gray_sync_decoder_pkg;
  localparam int PTR_DEFAULT = 4;
  localparam int SYNC_DEFAULT = 2;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic multi_bit(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a ^ b;
    return (d & (d - 32'd1)) != 32'd0;
  endfunction
endpackage

// File: rtl/gray_sync_decoder_g2b.sv
// gray_to_binary: combinational Gray-to-binary decode of a PTR-bit pointer
module gray_to_binary
  import gray_sync_decoder_pkg::*;
#(
  parameter int PTR = PTR_DEFAULT
) (
  input  logic [PTR-1:0] gray,
  output logic [PTR-1:0] bin
);
  assign bin = PTR'(gray2bin(32'(gray)));
endmodule

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: synchronize a foreign Gray pointer, decode it, report advance and Gray violations
module gray_sync_decoder
  import gray_sync_decoder_pkg::*;
#(
  parameter int PTR = PTR_DEFAULT,
  parameter int SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [PTR-1:0] gray_in,
  input  logic           err_clr,
  output logic [PTR-1:0] bin_out,
  output logic           bin_valid,
  output logic [PTR-1:0] delta,
  output logic           err_multi_bit
);
  localparam int FULL = SYNC_STAGES + 1;
  localparam int CW = $clog2(FULL + 1);
  logic [PTR-1:0] sync [SYNC_STAGES];
  logic [PTR-1:0] prev_g, dec;
  logic [CW-1:0]  cnt;
  for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sync
    if (k == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync[k] <= '0;
        else sync[k] <= gray_in;
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync[k] <= '0;
        else sync[k] <= sync[k-1];
    end
  end
  gray_to_binary #(.PTR(PTR)) u_g2b (.gray(sync[SYNC_STAGES-1]), .bin(dec));
  // bin_valid rises on the edge the counter saturates, i.e. when bin_out first holds post-reset data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      bin_valid <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(FULL)) ? cnt : cnt + CW'(1);
      bin_valid <= bin_valid | (cnt == CW'(FULL - 1));
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin_out <= '0;
      prev_g <= '0;
      delta <= '0;
      err_multi_bit <= 1'b0;
    end else begin
      bin_out <= dec;
      prev_g <= sync[SYNC_STAGES-1];
      delta <= bin_valid ? dec - bin_out : '0;
      err_multi_bit <= (bin_valid & multi_bit(32'(sync[SYNC_STAGES-1]), 32'(prev_g))) | (err_multi_bit & ~err_clr);
    end
endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder: directed table, corner sequences and randomized run against a history-based model
module tb_gray_sync_decoder;
  localparam int S = 2;
  logic clk = 1'b0, rst_n, err_clr;
  logic [3:0] gray_in, bin_out, delta;
  logic bin_valid, err_multi_bit;
  int checks = 0, failures = 0;
  int e;
  logic [3:0] gh[$];
  logic err_m;
  typedef struct { logic [3:0] g; logic [3:0] eb; logic [3:0] ed; } vec_t;
  vec_t tbl [20];

  gray_sync_decoder #(.PTR(4), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .delta(delta), .err_multi_bit(err_multi_bit)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dec(input logic [3:0] g);
    for (int i = 0; i < 16; i++) if (4'(i ^ (i >> 1)) == g) return 4'(i);
    return 4'd0;
  endfunction

  // bin_out after edge ed reflects the input sampled S edges earlier
  function automatic logic [3:0] exp_bin(input int ed);
    return (ed - S >= 1) ? dec(gh[ed-S-1]) : 4'd0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask

  task automatic model_reset();
    e = 0;
    gh.delete();
    err_m = 1'b0;
  endtask

  task automatic tick(input logic [3:0] g, input logic c);
    logic [3:0] d;
    logic set;
    gray_in = g;
    err_clr = c;
    @(posedge clk);
    gh.push_back(g);
    e++;
    set = (e - 1 >= S + 1) && ($countones(gh[e-S-1] ^ gh[e-S-2]) > 1);
    err_m = set | (err_m & ~c);
    @(negedge clk);
    d = (e - 1 >= S + 1) ? 4'(exp_bin(e) - exp_bin(e - 1)) : 4'd0;
    chk("m_valid", 32'(bin_valid), 32'(e >= S + 1));
    chk("m_bin", 32'(bin_out), 32'(exp_bin(e)));
    chk("m_delta", 32'(delta), 32'(d));
    chk("m_err", 32'(err_multi_bit), 32'(err_m));
  endtask

  task automatic do_reset(input logic [3:0] g);
    #2 rst_n = 1'b0;
    gray_in = g;
    err_clr = 1'b0;
    #1;
    chk("async_bin", 32'(bin_out), 0);
    chk("async_valid", 32'(bin_valid), 0);
    chk("async_delta", 32'(delta), 0);
    chk("async_err", 32'(err_multi_bit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] g;
    int r, a;
    tbl = '{'{4'h1,4'h0,4'h0}, '{4'h3,4'h0,4'h0}, '{4'h2,4'h1,4'h1}, '{4'h6,4'h2,4'h1},
            '{4'h7,4'h3,4'h1}, '{4'h5,4'h4,4'h1}, '{4'h4,4'h5,4'h1}, '{4'hc,4'h6,4'h1},
            '{4'hd,4'h7,4'h1}, '{4'hf,4'h8,4'h1}, '{4'he,4'h9,4'h1}, '{4'ha,4'ha,4'h1},
            '{4'hb,4'hb,4'h1}, '{4'h9,4'hc,4'h1}, '{4'h8,4'hd,4'h1}, '{4'h0,4'he,4'h1},
            '{4'h0,4'hf,4'h1}, '{4'h0,4'h0,4'h1}, '{4'h0,4'h0,4'h0}, '{4'h0,4'h0,4'h0}};
    rst_n = 1'b0;
    gray_in = '0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_valid", 32'(bin_valid), 0);
    chk("rst_delta", 32'(delta), 0);
    chk("rst_err", 32'(err_multi_bit), 0);
    rst_n = 1'b1;
    tick(4'h0, 1'b0); chk("fill1_valid", 32'(bin_valid), 0);
    tick(4'h0, 1'b0); chk("fill2_valid", 32'(bin_valid), 0);
    tick(4'h0, 1'b0); chk("fill3_valid", 32'(bin_valid), 1);
    tick(4'h1, 1'b0); chk("step_bin0", 32'(bin_out), 0);
    tick(4'h1, 1'b0); chk("step_bin1", 32'(bin_out), 0);
    tick(4'h1, 1'b0); chk("step_bin", 32'(bin_out), 1); chk("step_delta", 32'(delta), 1);
    tick(4'h1, 1'b0); chk("step_delta0", 32'(delta), 0); chk("step_err", 32'(err_multi_bit), 0);
    do_reset(4'h0);
    repeat (3) tick(4'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].g, 1'b0);
      chk($sformatf("sweep%0d_bin", i), 32'(bin_out), 32'(tbl[i].eb));
      chk($sformatf("sweep%0d_delta", i), 32'(delta), 32'(tbl[i].ed));
      chk($sformatf("sweep%0d_err", i), 32'(err_multi_bit), 0);
    end
    repeat (2) tick(4'h3, 1'b0);
    chk("viol_pre_err", 32'(err_multi_bit), 0);
    tick(4'h3, 1'b0);
    chk("viol_bin", 32'(bin_out), 2);
    chk("viol_delta", 32'(delta), 2);
    chk("viol_err", 32'(err_multi_bit), 1);
    repeat (2) tick(4'h3, 1'b0);
    chk("viol_sticky", 32'(err_multi_bit), 1);
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b1);
    chk("set_wins", 32'(err_multi_bit), 1);
    tick(4'h0, 1'b0);
    tick(4'h0, 1'b1);
    chk("clr_alone", 32'(err_multi_bit), 0);
    do_reset(4'h6);
    repeat (3) tick(4'h6, 1'b0);
    chk("mid_pre_bin", 32'(bin_out), 4);
    do_reset(4'h6);
    tick(4'h6, 1'b0);
    tick(4'h6, 1'b0);
    chk("mid_fill_valid", 32'(bin_valid), 0);
    tick(4'h6, 1'b0);
    chk("mid_valid", 32'(bin_valid), 1);
    chk("mid_bin", 32'(bin_out), 4);
    chk("mid_delta", 32'(delta), 0);
    g = 4'h6;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      a = $urandom_range(0, 3);
      if (r < 14) g = g ^ 4'(1 << a);
      else if (r < 16) g = g ^ 4'(1 << a) ^ 4'(1 << ((a + 1 + $urandom_range(0, 2)) % 4));
      if ($urandom_range(0, 59) == 0) do_reset(g);
      tick(g, $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
